// File: rtl/ball_motion_ctrl_pkg.sv
// Shared definitions for the Pong ball controller: FSM state encoding and direction constants.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SERVE  = 2'd1,
    ST_PLAY   = 2'd2,
    ST_SCORED = 2'd3
  } state_t;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  // A paddle sets the X direction absolutely; both paddles at once leave it alone.
  function automatic logic paddle_dir(input logic lpad, input logic rpad, input logic cur);
    logic dir;
    dir = cur;
    if (lpad && !rpad)
      dir = DIR_POS;
    else if (rpad && !lpad)
      dir = DIR_NEG;
    return dir;
  endfunction

endpackage

// File: rtl/ball_motion_ctrl_speed.sv
// Paddle-hit counter and saturating ball speed: every SPEEDUP_HITS effective hits add one pixel/frame.
module ball_speed_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SPEED_W      = 3,
  parameter int unsigned MIN_SPEED    = 1,
  parameter int unsigned MAX_SPEED    = 5,
  parameter int unsigned SPEEDUP_HITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_min,
  input  logic               effective_hit,
  output logic [SPEED_W-1:0] speed
);

  localparam int unsigned HIT_W = (SPEEDUP_HITS > 1) ? $clog2(SPEEDUP_HITS) : 1;
  localparam logic [SPEED_W-1:0] MIN_S = SPEED_W'(MIN_SPEED);
  localparam logic [SPEED_W-1:0] MAX_S = SPEED_W'(MAX_SPEED);
  localparam logic [HIT_W-1:0]   LAST_HIT = HIT_W'(SPEEDUP_HITS - 1);

  logic [HIT_W-1:0]   r_hit_cnt;
  logic [SPEED_W-1:0] r_speed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_cnt <= '0;
      r_speed   <= MIN_S;
    end else if (load_min) begin
      r_hit_cnt <= '0;
      r_speed   <= MIN_S;
    end else if (effective_hit) begin
      // The count keeps wrapping even once speed has saturated.
      if (r_hit_cnt == LAST_HIT) begin
        r_hit_cnt <= '0;
        if (r_speed < MAX_S)
          r_speed <= r_speed + 1'b1;
      end else begin
        r_hit_cnt <= r_hit_cnt + 1'b1;
      end
    end
  end

  assign speed = r_speed;

endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball direction / speed / serve sequencing for VGA Pong; updates once per frame_tick while in PLAY.
module ball_motion_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SPEED_W      = 3,
  parameter int unsigned MIN_SPEED    = 1,
  parameter int unsigned MAX_SPEED    = 5,
  parameter int unsigned SPEEDUP_HITS = 4,
  parameter int unsigned SERVE_DELAY  = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               game_en,
  input  logic               hit_lpad,
  input  logic               hit_rpad,
  input  logic               hit_top,
  input  logic               hit_bot,
  input  logic               miss_l,
  input  logic               miss_r,
  output logic               dir_x,
  output logic               dir_y,
  output logic [SPEED_W-1:0] speed,
  output logic               ball_active,
  output logic               recenter,
  output logic               score_l_inc,
  output logic               score_r_inc
);

  localparam int unsigned CNT_W = $clog2(SERVE_DELAY + 1);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_serve_cnt, w_serve_cnt_next;
  logic             r_dir_x, r_dir_y, r_ball_active, r_recenter, r_score_l, r_score_r;
  logic             w_dir_x_next, w_dir_y_next, w_ball_active_next, w_recenter_next;
  logic             w_score_l_next, w_score_r_next, w_load_min, w_eff_hit;
  logic             w_miss;

  assign w_miss = miss_l | miss_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_serve_cnt   <= '0;
      r_dir_x       <= DIR_NEG;
      r_dir_y       <= DIR_NEG;
      r_ball_active <= 1'b0;
      r_recenter    <= 1'b0;
      r_score_l     <= 1'b0;
      r_score_r     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_serve_cnt   <= w_serve_cnt_next;
      r_dir_x       <= w_dir_x_next;
      r_dir_y       <= w_dir_y_next;
      r_ball_active <= w_ball_active_next;
      r_recenter    <= w_recenter_next;
      r_score_l     <= w_score_l_next;
      r_score_r     <= w_score_r_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (!game_en) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_state_next = ST_SERVE;
        ST_SERVE:  if (frame_tick && r_serve_cnt == CNT_W'(1)) w_state_next = ST_PLAY;
        ST_PLAY:   if (frame_tick && w_miss) w_state_next = ST_SCORED;
        ST_SCORED: w_state_next = ST_SERVE;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_dir_x_next       = r_dir_x;
    w_dir_y_next       = r_dir_y;
    w_serve_cnt_next   = r_serve_cnt;
    w_recenter_next    = 1'b0;
    w_score_l_next     = 1'b0;
    w_score_r_next     = 1'b0;
    w_load_min         = 1'b0;
    w_eff_hit          = 1'b0;
    w_ball_active_next = (w_state_next == ST_PLAY);
    if (game_en) begin
      case (r_state)
        ST_IDLE: begin
          w_recenter_next  = 1'b1;
          w_serve_cnt_next = CNT_W'(SERVE_DELAY);
          w_load_min       = 1'b1;
        end
        ST_SERVE: if (frame_tick) w_serve_cnt_next = r_serve_cnt - 1'b1;
        ST_PLAY: if (frame_tick) begin
          if (w_miss) begin
            // Serve setup is registered on entry so it is already visible during SCORED.
            w_recenter_next  = 1'b1;
            w_serve_cnt_next = CNT_W'(SERVE_DELAY);
            w_load_min       = 1'b1;
            w_dir_y_next     = ~r_dir_y;
            if (miss_l && !miss_r) begin
              w_score_r_next = 1'b1;
              w_dir_x_next   = DIR_NEG;
            end else if (miss_r && !miss_l) begin
              w_score_l_next = 1'b1;
              w_dir_x_next   = DIR_POS;
            end
          end else begin
            w_dir_x_next = paddle_dir(hit_lpad, hit_rpad, r_dir_x);
            w_eff_hit    = (w_dir_x_next != r_dir_x);
            if (hit_top && !hit_bot)
              w_dir_y_next = DIR_POS;
            else if (hit_bot && !hit_top)
              w_dir_y_next = DIR_NEG;
          end
        end
        default: ;
      endcase
    end
  end

  ball_speed_ctrl #(
    .SPEED_W      (SPEED_W),
    .MIN_SPEED    (MIN_SPEED),
    .MAX_SPEED    (MAX_SPEED),
    .SPEEDUP_HITS (SPEEDUP_HITS)
  ) u_speed (
    .clk           (clk),
    .reset         (reset),
    .load_min      (w_load_min),
    .effective_hit (w_eff_hit),
    .speed         (speed)
  );

  assign dir_x       = r_dir_x;
  assign dir_y       = r_dir_y;
  assign ball_active = r_ball_active;
  assign recenter    = r_recenter;
  assign score_l_inc = r_score_l;
  assign score_r_inc = r_score_r;

endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
Parametrised ball-direction and speed controller for VGA Pong. It replaces the fixed four-direction ball FSM with independent X/Y direction bits, paddle-hit speed-up and serve/score sequencing. It sits in the control unit beside the NES controller FSMs and drives the datapath ball-position updater once per frame.

Parameters:
SPEED_W, 3, width of the speed output (pixels per frame)
MIN_SPEED, 1, speed loaded on every serve
MAX_SPEED, 5, saturation ceiling for speed (must be ≤ 2^SPEED_W-1)
SPEEDUP_HITS, 4, effective paddle hits per speed increment (≥1)
SERVE_DELAY, 60, frame_ticks the ball is held before play (≥1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
frame_tick  in  1  one-cycle pulse per video frame; all event sampling is qualified by it
game_en  in  1  level; low forces IDLE
hit_lpad  in  1  ball touching left paddle (level)
hit_rpad  in  1  ball touching right paddle (level)
hit_top  in  1  ball touching top border (level)
hit_bot  in  1  ball touching bottom border (level)
miss_l  in  1  ball passed left edge
miss_r  in  1  ball passed right edge
dir_x  out  1  0 = +x (right), 1 = -x (left)
dir_y  out  1  0 = +y (down), 1 = -y (up)
speed  out  SPEED_W  current magnitude
ball_active  out  1  high only in PLAY; datapath moves ball only when high
recenter  out  1  one-cycle pulse: datapath reloads centre position
score_l_inc  out  1  one-cycle pulse: left player scores
score_r_inc  out  1  one-cycle pulse: right player scores

Behaviour:
- All outputs registered. Reset: state=IDLE, dir_x=1, dir_y=1 (up-left), speed=MIN_SPEED, hit count 0, serve counter 0, ball_active/recenter/score pulses 0.
- States: IDLE, SERVE, PLAY, SCORED. game_en=0 in any state -> IDLE on the next clk; has priority over all else.
- IDLE: game_en=1 -> SERVE; recenter pulses for 1 cycle; serve counter loaded with SERVE_DELAY; speed=MIN_SPEED; hit count=0.
- SERVE: ball_active=0; counter decrements on each frame_tick; on the frame_tick that sees counter==1 -> PLAY. Exactly SERVE_DELAY frame_ticks spent in SERVE.
- PLAY: ball_active=1. Events evaluated only on cycles with frame_tick=1; results visible the following cycle.
  - Priority: miss > paddle/border. miss_l only -> SCORED, right scores. miss_r only -> SCORED, left scores. Both -> SCORED, no score.
  - Directions are set absolutely, never toggled (repeated level flags are harmless): hit_lpad -> dir_x=0; hit_rpad -> dir_x=1; hit_top -> dir_y=0; hit_bot -> dir_y=1. Both paddles together -> dir_x unchanged. Top+bottom together -> dir_y unchanged. X and Y updates are independent (corner hit updates both).
  - Effective hit = paddle hit that changes dir_x. Each effective hit increments hit count; the SPEEDUP_HITS-th resets count to 0 and increments speed, saturating at MAX_SPEED (count still wraps at saturation).
- SCORED: one cycle. score_r_inc (after miss_l) or score_l_inc (after miss_r) high this cycle only; recenter high. Serve direction: dir_x toward the player who lost the point (miss_l -> dir_x=1; miss_r -> dir_x=0; double miss -> unchanged); dir_y toggles every serve. speed=MIN_SPEED, hit count=0, serve counter=SERVE_DELAY. Next state SERVE.
- Reset asserted mid-operation: immediate return to reset values irrespective of state; pending pulses dropped.
- frame_tick during IDLE or SCORED is ignored.

Decomposition:
- Shared package pong_pkg: state encoding (2-bit IDLE=0, SERVE=1, PLAY=2, SCORED=3), DIR_POS=0 / DIR_NEG=1 constants.
- Sub-module ball_speed_ctrl: hit counter + saturating speed register with load_min and effective_hit inputs, parameterised by SPEED_W, MIN_SPEED, MAX_SPEED, SPEEDUP_HITS.

Test Plan:
(SERVE_DELAY=3, SPEEDUP_HITS=2, MIN_SPEED=1, MAX_SPEED=3)
- Reset then game_en=1 -> recenter 1 cycle, ball_active rises after exactly 3 frame_ticks; dir_x=1, dir_y=1, speed=1.
- PLAY, hit_top held for 5 frames -> dir_y=0 after first frame_tick, stays 0; dir_x unchanged; no speed change.
- Alternate hit_lpad/hit_rpad for 6 effective hits -> speed 1->2->3->3; hit_lpad repeated without hit_rpad -> count unchanged.
- hit_lpad+hit_rpad+hit_bot same frame -> dir_x unchanged, dir_y=1, speed unchanged.
- miss_l with hit_rpad same frame -> score_r_inc one cycle, recenter, dir_x=1, dir_y toggled, speed=1, SERVE for 3 ticks; miss_l+miss_r -> no score pulse.
- Reset asserted mid-SERVE and game_en dropped mid-PLAY -> reset values next edge asynchronously; IDLE next cycle with ball_active=0.
